// File: rtl/bsg_wormhole_inject_arbiter.sv
// +-----------------------------------------------------------------------------+
// | bsg_wormhole_inject_arbiter: round-robin wormhole arbiter for one injection   |
// | link; the grant is locked per packet. Optional counter macro:                 |
// | BSG_WORMHOLE_INJECT_ARBITER_STATS_EN. Revision: 1.0                           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module bsg_wormhole_inject_arbiter #(
  parameter int flit_width_p = 64,
  parameter int num_req_p    = 4,
  parameter int len_offset_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*flit_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_and_o,
  output logic [flit_width_p-1:0]           data_o,
  output logic                              v_o,
  input  logic                              ready_and_i,
  output logic [num_req_p-1:0]              grant_o,
  output logic                              busy_o,
  output logic [15:0]                       pkt_count_o
);

  localparam int                  ptr_w_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [ptr_w_lp:0]   num_req_lp  = (ptr_w_lp+1)'(num_req_p);
  localparam logic [ptr_w_lp-1:0] last_req_lp = ptr_w_lp'(num_req_p - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_r, state_n;
  logic [ptr_w_lp-1:0]     rr_ptr_r, rr_ptr_n;
  logic [ptr_w_lp-1:0]     owner_r, owner_n;
  logic [len_width_p-1:0]  remaining_r, remaining_n;

  logic [flit_width_p-1:0] flits [num_req_p];
  logic [ptr_w_lp-1:0]     winner;
  logic                    found;
  logic [ptr_w_lp:0]       cand;
  logic [ptr_w_lp-1:0]     sel;
  logic [ptr_w_lp-1:0]     next_ptr;
  logic [num_req_p-1:0]    grant_raw;
  logic [len_width_p-1:0]  hdr_len;
  logic                    xfer;
  logic                    last_body;

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign flits[g] = req_data_i[g*flit_width_p +: flit_width_p];
  end

  // Search upward from rr_ptr with wrap; the sum stays below 2*num_req_p.
  always_comb begin
    winner = rr_ptr_r;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = {1'b0, rr_ptr_r} + (ptr_w_lp+1)'(i);
      if (cand >= num_req_lp) cand = cand - num_req_lp;
      if (!found && req_v_i[cand[ptr_w_lp-1:0]]) begin
        found  = 1'b1;
        winner = cand[ptr_w_lp-1:0];
      end
    end
  end

  assign next_ptr = (winner == last_req_lp) ? '0 : winner + ptr_w_lp'(1);
  assign sel      = (state_r == BUSY) ? owner_r : winner;

  always_comb begin
    grant_raw = '0;
    if (state_r == BUSY) begin
      grant_raw = num_req_p'(1) << owner_r;
    end else if (found) begin
      grant_raw = num_req_p'(1) << winner;
    end
  end

  // Outputs are forced idle while reset is held, not just after the first edge.
  assign grant_o         = reset_n_i ? grant_raw : '0;
  assign data_o          = flits[sel];
  assign v_o             = req_v_i[sel] & (|grant_o);
  assign req_ready_and_o = {num_req_p{ready_and_i}} & grant_o;
  assign busy_o          = (state_r == BUSY);

  assign xfer      = v_o & ready_and_i;
  assign hdr_len   = data_o[len_offset_p +: len_width_p];
  assign last_body = (remaining_r == len_width_p'(1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      remaining_r <= '0;
    end else begin
      state_r     <= state_n;
      rr_ptr_r    <= rr_ptr_n;
      owner_r     <= owner_n;
      remaining_r <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state_r;
    rr_ptr_n    = rr_ptr_r;
    owner_n     = owner_r;
    remaining_n = remaining_r;
    case (state_r)
      IDLE: begin
        if (xfer) begin
          rr_ptr_n = next_ptr;
          if (hdr_len != '0) begin
            state_n     = BUSY;
            owner_n     = winner;
            remaining_n = hdr_len;
          end
        end
      end
      BUSY: begin
        // A stalled owner only inserts bubbles; arbitration resumes after the tail.
        if (xfer) begin
          remaining_n = remaining_r - len_width_p'(1);
          if (last_body) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef BSG_WORMHOLE_INJECT_ARBITER_STATS_EN
  logic        pkt_done;
  logic [15:0] pkt_count_r;

  assign pkt_done = xfer & (((state_r == IDLE) && (hdr_len == '0)) ||
                            ((state_r == BUSY) && last_body));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_count_r <= 16'h0;
    end else if (pkt_done) begin
      pkt_count_r <= pkt_count_r + 16'd1;
    end
  end

  assign pkt_count_o = pkt_count_r;
`else
  assign pkt_count_o = 16'h0;
`endif

endmodule

`default_nettype wire
